uart_tx_param: RTL and testbench



---
 rtl/uart_pkg.sv | 34 +++
 rtl/uart_baud_tick.sv | 38 +++
 rtl/uart_tx_param.sv | 187 ++++++++++++++++++
 tb/tb_uart_tx_param.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared constants for the parametrised UART transmitter: parity modes,
// FSM state encodings and the baud-rate divider table.
package uart_pkg;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_ODD  = 2'b01;
  localparam logic [1:0] PAR_EVEN = 2'b10;
  localparam logic [1:0] PAR_MARK = 2'b11;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  // Rounded clocks-per-bit for baud table entry sel.
  function automatic int unsigned baud_div(int unsigned clk_freq, int unsigned sel);
    longint unsigned baud;
    longint unsigned div;
    case (sel)
      0:       baud = 64'd9600;
      1:       baud = 64'd19200;
      2:       baud = 64'd38400;
      3:       baud = 64'd57600;
      4:       baud = 64'd115200;
      5:       baud = 64'd230400;
      6:       baud = 64'd460800;
      default: baud = 64'd921600;
    endcase
    div = (64'(clk_freq) + baud / 64'd2) / baud;
    return 32'(div);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Loadable 16-bit bit-period counter: pulses bit_end_o on the last clock of
// every DIV-clock period while enabled; a load restarts the period.
module uart_baud_tick (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_i,
  input  logic [15:0] div_i,
  input  logic        en_i,
  output logic        bit_end_o
);

  logic [15:0] div_q;
  logic [15:0] cnt_q, cnt_d;

  assign bit_end_o = en_i && (cnt_q == '0);

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = div_i - 16'd1;
    end else if (bit_end_o) begin
      cnt_d = div_q - 16'd1;
    end else if (en_i) begin
      cnt_d = cnt_q - 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q <= 16'd1;
      cnt_q <= '0;
    end else begin
      if (load_i) div_q <= div_i;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx_param.sv
// UART transmitter with runtime baud/parity/stop selection and valid/ready
// input; all outputs are registered so the serial line never glitches.
module uart_tx_param
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ     = 50_000_000,
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned DIV_OVERRIDE = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  input  logic [2:0]        baud_set,
  input  logic [1:0]        parity_mode,
  input  logic              stop2,
  output logic              uart_tx,
  output logic              tx_busy,
  output logic              tx_done
);

  localparam logic [3:0] LAST_BIT = 4'(DATA_W - 1);

  logic [15:0] div_tab [8];

  for (genvar g = 0; g < 8; g++) begin : g_div
    localparam int unsigned D = baud_div(CLK_FREQ, g);
    if (D > 65535 || D == 0) begin : g_bad
      $error("uart_tx_param: baud divider out of 16-bit range");
    end
    assign div_tab[g] = 16'(D);
  end

  if (DATA_W < 5 || DATA_W > 9) begin : g_bad_w
    $error("uart_tx_param: DATA_W must be 5..9");
  end
  if (DIV_OVERRIDE > 65535) begin : g_bad_ovr
    $error("uart_tx_param: DIV_OVERRIDE exceeds 16 bits");
  end

  logic [2:0]        state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [3:0]        bit_cnt_q, bit_cnt_d;
  logic              par_en_q, par_en_d;
  logic              par_bit_q, par_bit_d;
  logic              stop2_q, stop2_d;
  logic              stop_cnt_q, stop_cnt_d;
  logic              tx_q, tx_d;
  logic              ready_q, ready_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic        accept;
  logic        bit_end;
  logic [15:0] div_sel;

  assign accept  = tx_valid && ready_q;
  assign div_sel = (DIV_OVERRIDE != 0) ? 16'(DIV_OVERRIDE) : div_tab[baud_set];

  // The tick module latches div_sel on acceptance, freezing the bit period.
  uart_baud_tick u_tick (
    .clk       (clk),
    .rst       (rst),
    .load_i    (accept),
    .div_i     (div_sel),
    .en_i      (busy_q),
    .bit_end_o (bit_end)
  );

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    par_en_d   = par_en_q;
    par_bit_d  = par_bit_q;
    stop2_d    = stop2_q;
    stop_cnt_d = stop_cnt_q;
    tx_d       = tx_q;
    ready_d    = ready_q;
    busy_d     = busy_q;
    done_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          shift_d    = tx_data;
          par_en_d   = (parity_mode != PAR_NONE);
          if (parity_mode == PAR_ODD)       par_bit_d = ~^tx_data;
          else if (parity_mode == PAR_EVEN) par_bit_d = ^tx_data;
          else                              par_bit_d = 1'b1;
          stop2_d    = stop2;
          stop_cnt_d = 1'b0;
          bit_cnt_d  = '0;
          state_d    = ST_START;
          tx_d       = 1'b0;
          ready_d    = 1'b0;
          busy_d     = 1'b1;
        end
      end
      ST_START: begin
        if (bit_end) begin
          state_d   = ST_DATA;
          tx_d      = shift_q[0];
          shift_d   = shift_q >> 1;
          bit_cnt_d = '0;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          if (bit_cnt_q == LAST_BIT) begin
            if (par_en_q) begin
              state_d = ST_PARITY;
              tx_d    = par_bit_q;
            end else begin
              state_d = ST_STOP;
              tx_d    = 1'b1;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
            tx_d      = shift_q[0];
            shift_d   = shift_q >> 1;
          end
        end
      end
      ST_PARITY: begin
        if (bit_end) begin
          state_d = ST_STOP;
          tx_d    = 1'b1;
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          if (stop2_q && !stop_cnt_q) begin
            stop_cnt_d = 1'b1;
          end else begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
            ready_d = 1'b1;
            busy_d  = 1'b0;
            tx_d    = 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        tx_d    = 1'b1;
        ready_d = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
      stop2_q    <= 1'b0;
      stop_cnt_q <= 1'b0;
      tx_q       <= 1'b1;
      ready_q    <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      par_en_q   <= par_en_d;
      par_bit_q  <= par_bit_d;
      stop2_q    <= stop2_d;
      stop_cnt_q <= stop_cnt_d;
      tx_q       <= tx_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign uart_tx  = tx_q;
  assign tx_ready = ready_q;
  assign tx_busy  = busy_q;
  assign tx_done  = done_q;

endmodule

// File: tb/tb_uart_tx_param.sv
// Bench for uart_tx_param: three instances (table baud, DIV 16, 7-bit DIV 8)
// checked every cycle against a frame-waveform model plus literal checks.
module tb_uart_tx_param;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  logic [8:0] data_a  [3];
  logic       valid_a [3];
  logic [2:0] baud_a  [3];
  logic [1:0] pm_a    [3];
  logic       s2_a    [3];
  logic       line_a  [3];
  logic       busy_a  [3];
  logic       ready_a [3];
  logic       done_a  [3];

  uart_tx_param #(.CLK_FREQ(50_000_000), .DATA_W(8), .DIV_OVERRIDE(0)) u0 (
    .clk(clk), .rst(rst), .tx_data(data_a[0][7:0]), .tx_valid(valid_a[0]),
    .tx_ready(ready_a[0]), .baud_set(baud_a[0]), .parity_mode(pm_a[0]),
    .stop2(s2_a[0]), .uart_tx(line_a[0]), .tx_busy(busy_a[0]), .tx_done(done_a[0]));

  uart_tx_param #(.CLK_FREQ(50_000_000), .DATA_W(8), .DIV_OVERRIDE(16)) u1 (
    .clk(clk), .rst(rst), .tx_data(data_a[1][7:0]), .tx_valid(valid_a[1]),
    .tx_ready(ready_a[1]), .baud_set(baud_a[1]), .parity_mode(pm_a[1]),
    .stop2(s2_a[1]), .uart_tx(line_a[1]), .tx_busy(busy_a[1]), .tx_done(done_a[1]));

  uart_tx_param #(.CLK_FREQ(50_000_000), .DATA_W(7), .DIV_OVERRIDE(8)) u2 (
    .clk(clk), .rst(rst), .tx_data(data_a[2][6:0]), .tx_valid(valid_a[2]),
    .tx_ready(ready_a[2]), .baud_set(baud_a[2]), .parity_mode(pm_a[2]),
    .stop2(s2_a[2]), .uart_tx(line_a[2]), .tx_busy(busy_a[2]), .tx_done(done_a[2]));

  // Model: per instance, a queue of expected {line,busy,ready,done} per cycle.
  localparam logic [3:0] IDLE_E = 4'b1010;
  localparam logic [3:0] DONE_E = 4'b1011;
  int unsigned bauds [8] = '{9600, 19200, 38400, 57600, 115200, 230400, 460800, 921600};
  logic [3:0] q0[$], q1[$], q2[$];

  function automatic int model_div(int i, logic [2:0] b);
    if (i == 1) return 16;
    if (i == 2) return 8;
    return int'((50_000_000 + bauds[b] / 2) / bauds[b]);
  endfunction

  function automatic logic [3:0] head(int i);
    case (i)
      0:       return (q0.size() > 0) ? q0[0] : IDLE_E;
      1:       return (q1.size() > 0) ? q1[0] : IDLE_E;
      default: return (q2.size() > 0) ? q2[0] : IDLE_E;
    endcase
  endfunction

  task automatic drop(int i);
    case (i)
      0:       if (q0.size() > 0) q0.delete(0);
      1:       if (q1.size() > 0) q1.delete(0);
      default: if (q2.size() > 0) q2.delete(0);
    endcase
  endtask

  task automatic build(int i, output logic [3:0] fr[$]);
    int dw;
    int ones;
    int div;
    logic bits[$];
    dw   = (i == 2) ? 7 : 8;
    ones = 0;
    div  = model_div(i, baud_a[i]);
    fr   = {};
    bits.push_back(1'b0);
    for (int k = 0; k < dw; k++) begin
      bits.push_back(data_a[i][k]);
      ones += int'(data_a[i][k]);
    end
    case (pm_a[i])
      2'd1:    bits.push_back(ones % 2 == 0);
      2'd2:    bits.push_back(ones % 2 == 1);
      2'd3:    bits.push_back(1'b1);
      default: ;
    endcase
    bits.push_back(1'b1);
    if (s2_a[i]) bits.push_back(1'b1);
    foreach (bits[k]) repeat (div) fr.push_back({bits[k], 3'b100});
    fr.push_back(DONE_E);
  endtask

  task automatic append(int i, input logic [3:0] fr[$]);
    foreach (fr[k]) begin
      case (i)
        0:       q0.push_back(fr[k]);
        1:       q1.push_back(fr[k]);
        default: q2.push_back(fr[k]);
      endcase
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q0.delete();
      q1.delete();
      q2.delete();
    end else begin
      for (int i = 0; i < 3; i++) begin
        logic [3:0] cur;
        logic [3:0] fr[$];
        cur = head(i);
        drop(i);
        if (cur[1] && valid_a[i]) begin
          build(i, fr);
          append(i, fr);
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      logic [3:0] e;
      logic [3:0] a;
      e = head(i);
      a = {line_a[i], busy_a[i], ready_a[i], done_a[i]};
      total++;
      if (a !== e) begin
        bad++;
        $display("FAIL cmp_u%0d cyc=%0d got=%b want=%b (line,busy,ready,done)", i, cyc, a, e);
      end
    end
  end

  task automatic chk(string nm, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic at_cycle(int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic send(int i, logic [8:0] d, logic [2:0] b, logic [1:0] pm, logic s2,
                      output int c0);
    @(posedge clk);
    #1;
    data_a[i]  = d;
    baud_a[i]  = b;
    pm_a[i]    = pm;
    s2_a[i]    = s2;
    valid_a[i] = 1'b1;
    c0         = cyc;
    @(posedge clk);
    #1;
    valid_a[i] = 1'b0;
  endtask

  task automatic wait_done(int i, int limit, output int t);
    t = -1;
    while (cyc < limit) begin
      @(negedge clk);
      if (done_a[i]) begin
        t = cyc;
        break;
      end
    end
  endtask

  task automatic frame(int i, logic [8:0] d, logic [2:0] b, logic [1:0] pm, logic s2,
                       int div, int nb, logic [11:0] e, string nm);
    int c0;
    int t;
    send(i, d, b, pm, s2, c0);
    for (int k = 0; k < nb; k++) begin
      at_cycle(c0 + 1 + k * div + div / 2);
      chk($sformatf("%s_bit%0d", nm, k), int'(line_a[i]), int'(e[k]));
    end
    wait_done(i, c0 + nb * div + 20, t);
    chk({nm, "_done"}, t - c0, nb * div + 1);
  endtask

  initial begin
    int c0;
    int t;
    int highs;
    int ndone;
    for (int i = 0; i < 3; i++) begin
      data_a[i]  = '0;
      valid_a[i] = 1'b0;
      baud_a[i]  = 3'd4;
      pm_a[i]    = 2'd0;
      s2_a[i]    = 1'b0;
    end

    repeat (3) @(negedge clk);
    chk("rst_line",  int'(line_a[0]),  1);
    chk("rst_ready", int'(ready_a[0]), 1);
    chk("rst_busy",  int'(busy_a[0]),  0);
    chk("rst_done",  int'(done_a[0]),  0);
    @(posedge clk);
    #1 rst = 1'b0;

    // 115200 baud from the table: 434 clocks per bit.
    frame(0, 9'h09C, 3'd4, 2'd0, 1'b0, 434, 10, {2'b00, 1'b1, 8'h9C, 1'b0}, "t1");

    frame(1, 9'h0A9, 3'd0, 2'd2, 1'b0, 16, 11, {1'b0, 1'b1, 1'b0, 8'hA9, 1'b0}, "t2_even");
    frame(1, 9'h0A9, 3'd0, 2'd1, 1'b0, 16, 11, {1'b0, 1'b1, 1'b1, 8'hA9, 1'b0}, "t2_odd");
    frame(1, 9'h0A9, 3'd0, 2'd3, 1'b0, 16, 11, {1'b0, 1'b1, 1'b1, 8'hA9, 1'b0}, "t2_mark");

    send(2, 9'h055, 3'd0, 2'd0, 1'b1, c0);
    highs = 0;
    for (int k = c0 + 65; k <= c0 + 80; k++) begin
      at_cycle(k);
      if (line_a[2]) highs++;
    end
    chk("t3_stop_high", highs, 16);
    wait_done(2, c0 + 100, t);
    chk("t3_done", t - c0, 81);

    @(posedge clk);
    #1;
    data_a[1]  = 9'h001;
    pm_a[1]    = 2'd0;
    s2_a[1]    = 1'b0;
    valid_a[1] = 1'b1;
    c0         = cyc;
    ndone      = 0;
    while (cyc < c0 + 486) begin
      @(negedge clk);
      if (done_a[1]) ndone++;
      if (cyc == c0 + 1)   data_a[1] = 9'h002;
      if (cyc == c0 + 161) chk("t4_done1_line", int'(line_a[1]), 1);
      if (cyc == c0 + 162) begin
        chk("t4_start2_line", int'(line_a[1]), 0);
        data_a[1] = 9'h003;
      end
      if (cyc == c0 + 323) begin
        chk("t4_start3_line", int'(line_a[1]), 0);
        valid_a[1] = 1'b0;
      end
    end
    chk("t4_ndone", ndone, 3);

    send(0, 9'h05A, 3'd4, 2'd0, 1'b0, c0);
    at_cycle(c0 + 100);
    baud_a[0] = 3'd0;
    data_a[0] = 9'h0FF;
    at_cycle(c0 + 1 + 434 + 217);
    chk("t5_bit1", int'(line_a[0]), 0);
    at_cycle(c0 + 1 + 8 * 434 + 217);
    chk("t5_bit8", int'(line_a[0]), 0);
    wait_done(0, c0 + 4400, t);
    chk("t5_done", t - c0, 4341);
    frame(0, 9'h033, 3'd0, 2'd0, 1'b0, 5208, 10, {2'b00, 1'b1, 8'h33, 1'b0}, "t5b");

    send(1, 9'h0C3, 3'd0, 2'd0, 1'b0, c0);
    at_cycle(c0 + 1 + 4 * 16 + 5);
    chk("t6_pre_line", int'(line_a[1]), 0);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_line", int'(line_a[1]), 1);
    chk("t6_rst_busy", int'(busy_a[1]), 0);
    ndone = 0;
    repeat (3) begin
      @(negedge clk);
      if (done_a[1]) ndone++;
    end
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (120) begin
      @(negedge clk);
      if (done_a[1]) ndone++;
    end
    chk("t6_no_done", ndone, 0);
    chk("t6_ready", int'(ready_a[1]), 1);
    frame(1, 9'h05A, 3'd0, 2'd0, 1'b0, 16, 10, {2'b00, 1'b1, 8'h5A, 1'b0}, "t6_after");

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    bad++;
    $display("FAIL watchdog: got timeout want completion");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
